// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage: holds one instruction, waits for load data, commits to the register file
module writeback_stage #(
    parameter int MEM_TIMEOUT = 16,
    parameter int XP_INDEX    = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rc,
    input  logic        in_werf,
    input  logic [1:0]  in_wdsel,
    input  logic        in_xp,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [4:0]  Rc,
    output logic        WERF,
    output logic [31:0] WD,
    output logic        WASEL,
    output logic [4:0]  XPReg,
    output logic        byp_valid,
    output logic [4:0]  byp_rc,
    output logic [31:0] byp_data,
    output logic        err_timeout,
    output logic [31:0] instret
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic        xp;
        logic        werf;
        logic [1:0]  wdsel;
        logic [4:0]  rc;
        logic [31:0] alu;
        logic [31:0] pc4;
    } hold_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    hold_t         r_hold;

    logic w_accept;
    logic w_acc_load;
    logic w_mem_hit;
    logic w_timeout;
    logic w_commit_next;

    // Traps always write PC+4 to the exception register; R31 is hardwired zero.
    function automatic logic f_werf(input logic xp, input logic werf, input logic [4:0] rc);
        return xp | (werf & (rc != 5'd31));
    endfunction

    function automatic logic [31:0] f_wd(input logic xp, input logic [1:0] sel,
                                         input logic [31:0] pc4, input logic [31:0] alu,
                                         input logic [31:0] mem);
        if (xp)
            return pc4;
        case (sel)
            2'd0:    return pc4;
            2'd2:    return mem;
            default: return alu;
        endcase
    endfunction

    assign in_ready      = (r_state != S_WAIT_MEM);
    assign w_accept      = in_valid & in_ready;
    assign w_acc_load    = ~in_xp & (in_wdsel == 2'd2);
    assign w_mem_hit     = (r_state == S_WAIT_MEM) & mem_rd_valid;
    // Data arriving on the last allowed cycle wins over the timeout.
    assign w_timeout     = (r_state == S_WAIT_MEM) & ~mem_rd_valid & (r_cnt == CW'(MEM_TIMEOUT - 1));
    assign w_commit_next = (w_accept & ~w_acc_load) | w_mem_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_accept)
                    w_next = w_acc_load ? S_WAIT_MEM : S_COMMIT;
                else
                    w_next = S_IDLE;
            end
            S_WAIT_MEM: begin
                if (mem_rd_valid)
                    w_next = S_COMMIT;
                else if (w_timeout)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hold      <= '0;
            WERF        <= 1'b0;
            WASEL       <= 1'b0;
            Rc          <= 5'd0;
            WD          <= 32'd0;
            err_timeout <= 1'b0;
            instret     <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT_MEM && w_next == S_WAIT_MEM) ? r_cnt + CW'(1) : '0;

            if (w_accept)
                r_hold <= {in_xp, in_werf, in_wdsel, in_rc, in_alu, in_pc4};

            // Write port is loaded on the edge entering COMMIT, so it is stable for the whole cycle.
            WERF <= 1'b0;
            if (w_accept && !w_acc_load) begin
                WERF  <= f_werf(in_xp, in_werf, in_rc);
                WASEL <= in_xp;
                Rc    <= in_rc;
                WD    <= f_wd(in_xp, in_wdsel, in_pc4, in_alu, 32'd0);
            end else if (w_mem_hit) begin
                WERF  <= f_werf(r_hold.xp, r_hold.werf, r_hold.rc);
                WASEL <= r_hold.xp;
                Rc    <= r_hold.rc;
                WD    <= f_wd(r_hold.xp, r_hold.wdsel, r_hold.pc4, r_hold.alu, mem_rd_data);
            end

            if (w_commit_next)
                instret <= instret + 32'd1;
            if (w_timeout)
                err_timeout <= 1'b1;
        end
    end

    assign XPReg     = 5'(XP_INDEX);
    assign byp_valid = WERF;
    assign byp_rc    = WASEL ? XPReg : Rc;
    assign byp_data  = WD;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rc;
    logic        in_werf;
    logic [1:0]  in_wdsel;
    logic        in_xp;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [4:0]  Rc;
    logic        WERF;
    logic [31:0] WD;
    logic        WASEL;
    logic [4:0]  XPReg;
    logic        byp_valid;
    logic [4:0]  byp_rc;
    logic [31:0] byp_data;
    logic        err_timeout;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;
    logic exp_err = 1'b0;

    writeback_stage #(.MEM_TIMEOUT(16), .XP_INDEX(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rc(in_rc), .in_werf(in_werf), .in_wdsel(in_wdsel), .in_xp(in_xp),
        .in_alu(in_alu), .in_pc4(in_pc4),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .Rc(Rc), .WERF(WERF), .WD(WD), .WASEL(WASEL), .XPReg(XPReg),
        .byp_valid(byp_valid), .byp_rc(byp_rc), .byp_data(byp_data),
        .err_timeout(err_timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        xp;
        logic        werf;
        logic [1:0]  wdsel;
        logic [4:0]  rc;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] mem;
        int          lat;
        logic        e_werf;
        logic [31:0] e_wd;
        logic [4:0]  e_brc;
        logic        e_to;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction end to end; lat = empty memory cycles before data (>=16 means never).
    task automatic run_one(input vec_t v);
        logic is_load;
        int   n;
        is_load = !v.xp && (v.wdsel == 2'd2);
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_xp = v.xp; in_werf = v.werf; in_wdsel = v.wdsel;
        in_rc = v.rc; in_alu = v.alu; in_pc4 = v.pc4;
        step();
        in_valid = 1'b0;
        if (is_load) begin
            n = (v.lat < 16) ? v.lat : 16;
            for (int i = 0; i < n; i++) begin
                chk("wait_ready", 32'(in_ready), 32'd0);
                chk("wait_werf", 32'(WERF), 32'd0);
                in_valid = 1'b1;
                in_rc = 5'($urandom);
                step();
                in_valid = 1'b0;
            end
            if (v.lat >= 16) begin
                exp_err = 1'b1;
                chk("to_ready", 32'(in_ready), 32'd1);
                chk("to_werf", 32'(WERF), 32'd0);
                chk("to_err", 32'(err_timeout), 32'(exp_err));
                chk("to_instret", instret, 32'(exp_instret));
                return;
            end
            mem_rd_valid = 1'b1;
            mem_rd_data  = v.mem;
            step();
            mem_rd_valid = 1'b0;
            mem_rd_data  = 32'($urandom);
        end
        exp_instret++;
        chk("c_werf", 32'(WERF), 32'(v.e_werf));
        chk("c_wd", WD, v.e_wd);
        chk("c_byp_rc", 32'(byp_rc), 32'(v.e_brc));
        chk("c_byp_valid", 32'(byp_valid), 32'(v.e_werf));
        chk("c_byp_data", byp_data, v.e_wd);
        chk("c_wasel", 32'(WASEL), 32'(v.xp));
        if (!v.xp) chk("c_rc", 32'(Rc), 32'(v.rc));
        chk("c_instret", instret, 32'(exp_instret));
        chk("c_err", 32'(err_timeout), 32'(exp_err));
        chk("c_ready", 32'(in_ready), 32'd1);
        step();
        chk("post_werf", 32'(WERF), 32'd0);
        chk("post_byp_valid", 32'(byp_valid), 32'd0);
    endtask

    // Reference: the commit the ISA rules demand for one instruction.
    function automatic vec_t model(input logic xp, input logic werf, input logic [1:0] wdsel,
                                   input logic [4:0] rc, input logic [31:0] alu,
                                   input logic [31:0] pc4, input logic [31:0] mem, input int lat);
        vec_t v;
        v.xp = xp; v.werf = werf; v.wdsel = wdsel; v.rc = rc;
        v.alu = alu; v.pc4 = pc4; v.mem = mem; v.lat = lat;
        v.e_to = !xp && wdsel == 2'd2 && lat >= 16;
        if (xp) begin
            v.e_werf = 1'b1; v.e_wd = pc4; v.e_brc = 5'd30;
        end else begin
            v.e_werf = werf && rc != 5'd31;
            v.e_brc  = rc;
            if (wdsel == 2'd0)      v.e_wd = pc4;
            else if (wdsel == 2'd2) v.e_wd = mem;
            else                    v.e_wd = alu;
        end
        return v;
    endfunction

    initial begin
        logic [4:0] b2b_rc [4];
        vec_t v;

        tbl[0]  = '{1'b0, 1'b1, 2'd1, 5'd5,  32'h12345678, 32'h0,    32'h0,        0,  1'b1, 32'h12345678, 5'd5,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 5'd7,  32'h1111,     32'h2222, 32'hDEADBEEF, 3,  1'b1, 32'hDEADBEEF, 5'd7,  1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 5'd9,  32'h33,       32'h104,  32'h55,       0,  1'b1, 32'h104,      5'd30, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 5'd12, 32'hAAAA,     32'h400,  32'h0,        0,  1'b1, 32'h400,      5'd12, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd3, 5'd3,  32'hCAFE0003, 32'h8,    32'h0,        0,  1'b1, 32'hCAFE0003, 5'd3,  1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 5'd6,  32'h77,       32'h0,    32'h0,        0,  1'b0, 32'h77,       5'd6,  1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 5'd31, 32'h99,       32'h0,    32'h0,        0,  1'b0, 32'h99,       5'd31, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 5'd20, 32'h0,        32'h0,    32'h0BADF00D, 15, 1'b1, 32'h0BADF00D, 5'd20, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 5'd21, 32'h0,        32'h0,    32'h1234,     16, 1'b0, 32'h0,        5'd0,  1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 5'd22, 32'h5A5A5A5A, 32'h0,    32'h0,        0,  1'b1, 32'h5A5A5A5A, 5'd22, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'd2, 5'd31, 32'h0,        32'h0,    32'hFEED,     0,  1'b0, 32'hFEED,     5'd31, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_rc = '0; in_werf = 1'b0; in_wdsel = '0;
        in_xp = 1'b0; in_alu = '0; in_pc4 = '0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        step(); step();
        chk("rst_werf", 32'(WERF), 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_rc", 32'(Rc), 32'd0);
        chk("rst_wasel", 32'(WASEL), 32'd0);
        chk("rst_byp_valid", 32'(byp_valid), 32'd0);
        chk("rst_byp_rc", 32'(byp_rc), 32'd0);
        chk("rst_byp_data", byp_data, 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("xpreg", 32'(XPReg), 32'd30);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run_one(tbl[i]);

        // Back-to-back ALU ops, third one targets R31.
        b2b_rc[0] = 5'd1; b2b_rc[1] = 5'd2; b2b_rc[2] = 5'd31; b2b_rc[3] = 5'd4;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_xp = 1'b0; in_werf = 1'b1; in_wdsel = 2'd1;
            in_rc = b2b_rc[k]; in_alu = 32'h100 * k + 32'(b2b_rc[k]); in_pc4 = 32'h0;
            step();
            exp_instret++;
            chk("b2b_werf", 32'(WERF), (k == 2) ? 32'd0 : 32'd1);
            chk("b2b_rc", 32'(Rc), 32'(b2b_rc[k]));
            chk("b2b_wd", WD, 32'h100 * k + 32'(b2b_rc[k]));
            chk("b2b_instret", instret, 32'(exp_instret));
            chk("b2b_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_idle_werf", 32'(WERF), 32'd0);

        for (int n = 0; n < 40; n++) begin
            v = model(($urandom % 6) == 0, 1'($urandom), 2'($urandom),
                      (($urandom % 4) == 0) ? 5'd31 : 5'($urandom),
                      $urandom, $urandom, $urandom, int'($urandom_range(0, 17)));
            run_one(v);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                chk("gap_werf", 32'(WERF), 32'd0);
            end
        end

        // Reset while a load is pending: no write, late data ignored.
        in_valid = 1'b1; in_xp = 1'b0; in_werf = 1'b1; in_wdsel = 2'd2; in_rc = 5'd8;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_werf", 32'(WERF), 32'd0);
        chk("rw_wd", WD, 32'd0);
        chk("rw_rc", 32'(Rc), 32'd0);
        chk("rw_byp_valid", 32'(byp_valid), 32'd0);
        chk("rw_byp_data", byp_data, 32'd0);
        chk("rw_instret", instret, 32'd0);
        chk("rw_err", 32'(err_timeout), 32'd0);
        chk("rw_ready", 32'(in_ready), 32'd1);
        mem_rd_valid = 1'b1; mem_rd_data = 32'hABCDEF01;
        step();
        mem_rd_valid = 1'b0;
        chk("rw_late_werf", 32'(WERF), 32'd0);
        chk("rw_late_instret", instret, 32'd0);
        step();
        chk("rw_late_werf2", 32'(WERF), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the number of WAIT_MEM cycles allowed before the load is abandoned.
REQ-002 SHALL have parameter XP_INDEX, default 30, meaning the exception-pointer register index.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 in_valid  in  1  upstream (memory stage) instruction valid.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 in_rc  in  5  destination register index.
REQ-008 in_werf  in  1  instruction writes the register file.
REQ-009 in_wdsel  in  2  write-data source: 0 = PC+4, 1 = ALU, 2 = memory read, 3 = reserved (treated as 1).
REQ-010 in_xp  in  1  exception/trap; PC+4 is saved to XP_INDEX.
REQ-011 in_alu  in  32  ALU result.
REQ-012 in_pc4  in  32  PC+4 of the instruction.
REQ-013 mem_rd_valid  in  1  load data valid.
REQ-014 mem_rd_data  in  32  load data.
REQ-015 Rc / WERF / WD / WASEL / XPReg  out  5/1/32/1/5  register-file write port (drives the regfile block directly).
REQ-016 byp_valid / byp_rc / byp_data  out  1/5/32  forwarding of the committing write to the operand-fetch stage.
REQ-017 err_timeout  out  1  sticky load-timeout flag.
REQ-018 instret  out  32  count of committed instructions.

Function
REQ-019 SHALL implement states IDLE, WAIT_MEM and COMMIT in a registered state machine.
REQ-020 in_ready SHALL be 1 in IDLE and COMMIT, and 0 in WAIT_MEM.
REQ-021 An instruction SHALL be accepted on a rising edge where in_valid && in_ready; all in_* fields are captured into a holding register at that edge.
REQ-022 On accept, if in_xp = 0 and in_wdsel = 2, next state SHALL be WAIT_MEM; otherwise next state SHALL be COMMIT.
REQ-023 In COMMIT with no new accept, next state SHALL be IDLE; with a new accept, next state follows REQ-022, giving back-to-back one-per-cycle throughput for non-load instructions.
REQ-024 In WAIT_MEM, mem_rd_valid = 1 SHALL capture mem_rd_data and move to COMMIT; mem_rd_valid SHALL be ignored in every other state.
REQ-025 WAIT_MEM SHALL count cycles from 0; if MEM_TIMEOUT cycles pass without mem_rd_valid, the stage SHALL go to IDLE, drop the write (no WERF, no instret increment), and set err_timeout.
REQ-026 If mem_rd_valid arrives on the same cycle the count reaches MEM_TIMEOUT, the data SHALL win: commit proceeds and no timeout is flagged.
REQ-027 Write outputs SHALL be registered: WERF is 1 only during the COMMIT cycle, and WD/Rc/WASEL are stable and valid in that cycle.
REQ-028 WD SHALL select in_pc4 when wdsel = 0, in_alu when wdsel = 1 or 3, and captured load data when wdsel = 2.
REQ-029 If in_xp = 1: WASEL = 1, WD = captured in_pc4, and WERF = 1, regardless of in_werf and in_wdsel.
REQ-030 If in_xp = 0: WASEL = 0 and WERF = in_werf && (in_rc != 31); a write to R31 is suppressed.
REQ-031 XPReg SHALL be the constant XP_INDEX.
REQ-032 In COMMIT, byp_valid SHALL equal WERF, byp_rc SHALL be (WASEL ? XPReg : Rc), and byp_data SHALL equal WD; byp_valid SHALL be 0 outside COMMIT.
REQ-033 instret SHALL increment by 1 on each COMMIT cycle, including suppressed-R31 commits and non-writing instructions, and wrap from 0xFFFFFFFF to 0.
REQ-034 err_timeout SHALL remain set until reset and SHALL not block further operation.

Reset
REQ-035 When rst_n = 0 at a rising edge: state becomes IDLE, the WAIT_MEM counter is 0, the holding register is cleared, and WERF, WASEL, byp_valid, err_timeout, instret, WD, Rc and byp_* are all 0.
REQ-036 Reset asserted mid-WAIT_MEM SHALL abandon the load without any write; in_ready is 1 on the first cycle after reset releases.

Verification
REQ-037 ALU op: accept rc = 5, wdsel = 1, alu = 0x12345678, werf = 1 -> next cycle WERF = 1, Rc = 5, WD = 0x12345678, byp_rc = 5, instret = 1.
REQ-038 Load: accept rc = 7, wdsel = 2; mem_rd_valid with data 0xDEADBEEF 3 cycles later -> in_ready = 0 during the wait, then one COMMIT with WD = 0xDEADBEEF.
REQ-039 Trap: in_xp = 1, in_pc4 = 0x104, in_werf = 0 -> WERF = 1, WASEL = 1, XPReg = 30, WD = 0x104, byp_rc = 30.
REQ-040 R31 and throughput: 4 back-to-back ALU ops, the third with rc = 31 -> commits in 4 consecutive cycles, WERF = 0 on the third, instret = 4.
REQ-041 Timeout: load with no mem_rd_valid for 16 cycles -> no WERF, err_timeout = 1, state IDLE; a following ALU op still commits normally.
REQ-042 Reset in WAIT_MEM: rst_n = 0 during a pending load -> all outputs 0, and a late mem_rd_valid after release causes no write.
